// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared widths and encodings for the RISC-V execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RESULT_ALU = 2'b00;
  localparam logic [1:0] RESULT_MEM = 2'b01;
  localparam logic [1:0] RESULT_PC4 = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module      : alu
// Description : Integer ALU for the execute stage, with a subtract-based Zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic [2:0]      i_alu_control,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);
  import riscv_pkg::*;

  localparam int SHAMT_W = $clog2(XLEN);

  logic [XLEN-1:0] w_diff;
  logic            w_lt;
  logic            w_ltu;

  assign w_diff = i_src_a - i_src_b;
  assign w_lt   = $signed(i_src_a) < $signed(i_src_b);
  assign w_ltu  = i_src_a < i_src_b;
  assign o_zero = (w_diff == '0);

  always_comb begin
    o_result = '0;
    case (i_alu_control)
      ALU_ADD:  o_result = i_src_a + i_src_b;
      ALU_SUB:  o_result = w_diff;
      ALU_AND:  o_result = i_src_a & i_src_b;
      ALU_OR:   o_result = i_src_a | i_src_b;
      ALU_XOR:  o_result = i_src_a ^ i_src_b;
      ALU_SLT:  o_result = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLTU: o_result = {{(XLEN-1){1'b0}}, w_ltu};
      ALU_SLL:  o_result = i_src_a << i_src_b[SHAMT_W-1:0];
      default:  o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage
// Description : RISC-V EX stage: operand forwarding, ALU, branch resolution
//               and the EX/MEM pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              MemWriteE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic              ALUSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic [2:0]        Funct3E,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [XLEN-1:0]   ImmExtE,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [XLEN-1:0]   ResultW,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [XLEN-1:0]   ALU_ResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M
);
  import riscv_pkg::*;

  logic [XLEN-1:0]   w_src_a;
  logic [XLEN-1:0]   w_fwd_b;
  logic [XLEN-1:0]   w_src_b;
  logic [XLEN-1:0]   w_alu_result;
  logic              w_zero;
  logic              w_lt;
  logic              w_ltu;
  logic              w_branch_cond;

  logic              r_reg_write_m;
  logic              r_mem_write_m;
  logic [1:0]        r_result_src_m;
  logic [REG_AW-1:0] r_rd_m;
  logic [XLEN-1:0]   r_alu_result_m;
  logic [XLEN-1:0]   r_write_data_m;
  logic [XLEN-1:0]   r_pc_plus4_m;

  // MEM-stage forwarding reads the already-registered previous result.
  always_comb begin
    w_src_a = RD1_E;
    case (ForwardAE)
      FWD_WB:  w_src_a = ResultW;
      FWD_MEM: w_src_a = r_alu_result_m;
      default: w_src_a = RD1_E;
    endcase
  end

  always_comb begin
    w_fwd_b = RD2_E;
    case (ForwardBE)
      FWD_WB:  w_fwd_b = ResultW;
      FWD_MEM: w_fwd_b = r_alu_result_m;
      default: w_fwd_b = RD2_E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmExtE : w_fwd_b;

  alu #(.XLEN(XLEN)) u_alu (
    .i_src_a       (w_src_a),
    .i_src_b       (w_src_b),
    .i_alu_control (ALUControlE),
    .o_result      (w_alu_result),
    .o_zero        (w_zero)
  );

  assign w_lt  = $signed(w_src_a) < $signed(w_src_b);
  assign w_ltu = w_src_a < w_src_b;

  always_comb begin
    w_branch_cond = 1'b0;
    case (Funct3E)
      F3_BEQ:  w_branch_cond = w_zero;
      F3_BNE:  w_branch_cond = ~w_zero;
      F3_BLT:  w_branch_cond = w_lt;
      F3_BGE:  w_branch_cond = ~w_lt;
      F3_BLTU: w_branch_cond = w_ltu;
      F3_BGEU: w_branch_cond = ~w_ltu;
      default: w_branch_cond = 1'b0;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & w_branch_cond);
  assign PCTargetE = PCE + ImmExtE;

  // No enable or flush: wrong-path squashing happens upstream in ID/EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg_write_m  <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_result_src_m <= RESULT_ALU;
      r_rd_m         <= '0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_pc_plus4_m   <= '0;
    end else begin
      r_reg_write_m  <= RegWriteE;
      r_mem_write_m  <= MemWriteE;
      r_result_src_m <= ResultSrcE;
      r_rd_m         <= RD_E;
      r_alu_result_m <= w_alu_result;
      r_write_data_m <= w_fwd_b;
      r_pc_plus4_m   <= PCPlus4E;
    end
  end

  assign RegWriteM   = r_reg_write_m;
  assign MemWriteM   = r_mem_write_m;
  assign ResultSrcM  = r_result_src_m;
  assign RD_M        = r_rd_m;
  assign ALU_ResultM = r_alu_result_m;
  assign WriteDataM  = r_write_data_m;
  assign PCPlus4M    = r_pc_plus4_m;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage
// Description : Self-checking bench for execute_stage against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1_E, RD2_E, PCE, PCPlus4E, ImmExtE, ResultW;
  logic [4:0]  RD_E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUSrcE(ALUSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ImmExtE(ImmExtE), .RD_E(RD_E), .ResultW(ResultW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        exp_rw, exp_mw;
  logic [1:0]  exp_rs;
  logic [4:0]  exp_rd;
  logic [31:0] exp_alu, exp_wd, exp_pc4;

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] rf,
                                      input logic [31:0] wb, input logic [31:0] mem);
    if (s == 2'd1) return wb;
    if (s == 2'd2) return mem;
    return rf;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      3'd6: return (a < b) ? 32'd1 : 32'd0;
      default: return a << (b % 32);
    endcase
  endfunction

  function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return int'(a) < int'(b);
      3'd5: return int'(a) >= int'(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_src_a();
    return fwd(ForwardAE, RD1_E, ResultW, exp_alu);
  endfunction

  function automatic logic [31:0] m_fwd_b();
    return fwd(ForwardBE, RD2_E, ResultW, exp_alu);
  endfunction

  function automatic logic [31:0] m_src_b();
    return ALUSrcE ? ImmExtE : m_fwd_b();
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_rw <= 1'b0; exp_mw <= 1'b0; exp_rs <= 2'd0; exp_rd <= 5'd0;
      exp_alu <= 32'd0; exp_wd <= 32'd0; exp_pc4 <= 32'd0;
    end else begin
      exp_rw  <= RegWriteE;
      exp_mw  <= MemWriteE;
      exp_rs  <= ResultSrcE;
      exp_rd  <= RD_E;
      exp_alu <= alu_ref(ALUControlE, m_src_a(), m_src_b());
      exp_wd  <= m_fwd_b();
      exp_pc4 <= PCPlus4E;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare process: every negedge while out of reset.
  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("m_pcsrc",  {31'd0, PCSrcE}, {31'd0, JumpE | (BranchE & br_ref(Funct3E, m_src_a(), m_src_b()))});
      chk("m_target", PCTargetE, PCE + ImmExtE);
      chk("m_regw",   {31'd0, RegWriteM}, {31'd0, exp_rw});
      chk("m_memw",   {31'd0, MemWriteM}, {31'd0, exp_mw});
      chk("m_ressrc", {30'd0, ResultSrcM}, {30'd0, exp_rs});
      chk("m_rd",     {27'd0, RD_M}, {27'd0, exp_rd});
      chk("m_alu",    ALU_ResultM, exp_alu);
      chk("m_wdata",  WriteDataM, exp_wd);
      chk("m_pc4",    PCPlus4M, exp_pc4);
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_inputs();
    RegWriteE = 0; MemWriteE = 0; BranchE = 0; JumpE = 0; ALUSrcE = 0;
    ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0; ALUControlE = 0; Funct3E = 0;
    RD1_E = 0; RD2_E = 0; PCE = 0; PCPlus4E = 0; ImmExtE = 0; ResultW = 0; RD_E = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    ALUControlE = op; RD1_E = a; RD2_E = b;
  endtask

  initial begin
    clear_inputs();
    #12;
    chk("rst_alu", ALU_ResultM, 32'd0);
    chk("rst_regw", {31'd0, RegWriteM}, 32'd0);
    chk("rst_pc4", PCPlus4M, 32'd0);
    #10 rst = 1'b1;
    chk_en = 1'b1;

    // Back-to-back forwarding from the registered MEM result.
    next();
    clear_inputs();
    RD1_E = 3; RD2_E = 4; RD_E = 7; RegWriteE = 1;
    next();
    chk("fwd_c1", ALU_ResultM, 32'd7);
    clear_inputs();
    ForwardAE = 2'b10; RD1_E = 0; RD2_E = 1;
    next();
    chk("fwd_c2", ALU_ResultM, 32'd8);
    clear_inputs();
    ALUControlE = 3'b011; ForwardBE = 2'b01; ResultW = 32'h55;
    next();
    chk("fwd_wb_alu", ALU_ResultM, 32'h55);
    chk("fwd_wb_wd", WriteDataM, 32'h55);

    // Branch conditions.
    clear_inputs();
    BranchE = 1; Funct3E = 3'b100; RD1_E = 32'hFFFF_FFFF; RD2_E = 1;
    #1 chk("blt", {31'd0, PCSrcE}, 32'd1);
    next();
    Funct3E = 3'b110;
    #1 chk("bltu", {31'd0, PCSrcE}, 32'd0);
    next();
    Funct3E = 3'b000; RD1_E = 5; RD2_E = 5;
    #1 chk("beq", {31'd0, PCSrcE}, 32'd1);
    next();
    Funct3E = 3'b010;
    #1 chk("f3_010", {31'd0, PCSrcE}, 32'd0);
    next();
    clear_inputs();
    JumpE = 1; PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
    #1 chk("jump", {31'd0, PCSrcE}, 32'd1);
    chk("target", PCTargetE, 32'hF0);

    // ALU boundaries.
    next();
    alu_op(3'b000, 32'hFFFF_FFFF, 32'd1);
    next();
    chk("add_wrap", ALU_ResultM, 32'd0);
    alu_op(3'b001, 32'd0, 32'd1);
    next();
    chk("sub_wrap", ALU_ResultM, 32'hFFFF_FFFF);
    alu_op(3'b101, 32'h8000_0000, 32'd1);
    next();
    chk("slt_neg", ALU_ResultM, 32'd1);
    alu_op(3'b111, 32'd1, 32'd0);
    ALUSrcE = 1; ImmExtE = 32'h23;
    next();
    chk("sll_mask", ALU_ResultM, 32'd8);

    // Store path.
    clear_inputs();
    ALUSrcE = 1; ImmExtE = 8; RD1_E = 32'h10; RD2_E = 32'hAB; MemWriteE = 1;
    next();
    chk("st_addr", ALU_ResultM, 32'h18);
    chk("st_data", WriteDataM, 32'hAB);
    chk("st_memw", {31'd0, MemWriteM}, 32'd1);

    // Asynchronous reset mid-instruction.
    clear_inputs();
    RegWriteE = 1; RD_E = 5;
    next();
    chk("pre_rst_rd", {27'd0, RD_M}, 32'd5);
    #2 rst = 1'b0;
    #1;
    chk("arst_rd", {27'd0, RD_M}, 32'd0);
    chk("arst_regw", {31'd0, RegWriteM}, 32'd0);
    chk("arst_alu", ALU_ResultM, 32'd0);
    #2 rst = 1'b1;
    next();
    chk("post_rst_rd", {27'd0, RD_M}, 32'd5);
    chk("post_rst_regw", {31'd0, RegWriteM}, 32'd1);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 400; i++) begin
      RegWriteE   = 1'($urandom);
      MemWriteE   = 1'($urandom);
      BranchE     = 1'($urandom);
      JumpE       = ($urandom_range(0, 7) == 0);
      ALUSrcE     = 1'($urandom);
      ResultSrcE  = 2'($urandom_range(0, 2));
      ForwardAE   = 2'($urandom);
      ForwardBE   = 2'($urandom);
      ALUControlE = 3'($urandom);
      Funct3E     = 3'($urandom);
      RD1_E       = ($urandom_range(0, 3) == 0) ? RD2_E : $urandom;
      RD2_E       = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      PCE         = $urandom & 32'hFFFF_FFFC;
      PCPlus4E    = PCE + 4;
      ImmExtE     = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
      ResultW     = $urandom;
      RD_E        = 5'($urandom);
      next();
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
